// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control unit: FSM states,
// instruction classes, opcode constants and mux-select codes.
package rv32_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_R       = 4'd0,
    CLS_IALU    = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LUI     = 4'd5,
    CLS_AUIPC   = 4'd6,
    CLS_JAL     = 4'd7,
    CLS_JALR    = 4'd8,
    CLS_ILLEGAL = 4'd9
  } cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // Immediate format needed by each instruction class.
  function automatic logic [2:0] imm_type_of(input cls_e c);
    logic [2:0] t;
    t = IMM_NONE;
    case (c)
      CLS_IALU, CLS_LOAD, CLS_JALR: t = IMM_I;
      CLS_STORE:                    t = IMM_S;
      CLS_BRANCH:                   t = IMM_B;
      CLS_LUI, CLS_AUIPC:           t = IMM_U;
      CLS_JAL:                      t = IMM_J;
      default:                      t = IMM_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier: maps instr[6:0] to an instruction class.
module opcode_class
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_e       cls
);

  // Unknown opcodes fall through to CLS_ILLEGAL.
  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_IALU:   cls = CLS_IALU;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_LUI:    cls = CLS_LUI;
      OP_AUIPC:  cls = CLS_AUIPC;
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   cls = CLS_JALR;
      default:   cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM. Outputs are decoded combinationally from the
// registered state, the IR contents and mem_ready, and are held at 0 while
// rst_n is low so an in-flight access is abandoned without side effects.
module multicycle_ctrl
  import rv32_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        retire,
  output logic        illegal,
  output logic [1:0]  pc_sel,
  output logic [1:0]  wb_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [2:0]  imm_type,
  output logic [2:0]  state_o
);

  state_e state;
  state_e state_nxt;
  cls_e   cls;
  logic   rd_zero;
  logic   unused_instr;

  opcode_class u_opcode_class (
    .opcode (instr[6:0]),
    .cls    (cls)
  );

  assign rd_zero      = (instr[11:7] == 5'd0);
  // Upper instruction fields are consumed by the datapath, not the controller.
  assign unused_instr = ^instr[31:12];
  assign state_o      = state;

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  // Next-state and output decode; all outputs stay 0 while reset is held.
  always_comb begin
    state_nxt    = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    reg_we       = 1'b0;
    retire       = 1'b0;
    illegal      = 1'b0;
    pc_sel       = PC_PLUS4;
    wb_sel       = WB_ALU;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    imm_type     = 3'd0;
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we     = 1'b1;
            state_nxt = ST_DECODE;
          end
        end
        ST_DECODE: begin
          imm_type  = imm_type_of(cls);
          state_nxt = (cls == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
        end
        ST_EXEC: begin
          imm_type  = imm_type_of(cls);
          alu_a_sel = (cls == CLS_AUIPC);
          alu_b_sel = (cls != CLS_R) && (cls != CLS_BRANCH);
          if (cls == CLS_BRANCH) begin
            pc_we     = 1'b1;
            pc_sel    = branch_taken ? PC_IMM : PC_PLUS4;
            retire    = 1'b1;
            state_nxt = ST_FETCH;
          end else if ((cls == CLS_LOAD) || (cls == CLS_STORE)) begin
            state_nxt = ST_MEM;
          end else begin
            state_nxt = ST_WB;
          end
        end
        ST_MEM: begin
          imm_type     = imm_type_of(cls);
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (cls == CLS_STORE);
          if (mem_ready) begin
            if (cls == CLS_STORE) begin
              pc_we     = 1'b1;
              pc_sel    = PC_PLUS4;
              retire    = 1'b1;
              state_nxt = ST_FETCH;
            end else begin
              state_nxt = ST_WB;
            end
          end
        end
        ST_WB: begin
          imm_type  = imm_type_of(cls);
          reg_we    = !rd_zero;
          pc_we     = 1'b1;
          retire    = 1'b1;
          state_nxt = ST_FETCH;
          case (cls)
            CLS_LOAD:          wb_sel = WB_MEM;
            CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
            CLS_LUI:           wb_sel = WB_IMM;
            default:           wb_sel = WB_ALU;
          endcase
          case (cls)
            CLS_JAL:  pc_sel = PC_IMM;
            CLS_JALR: pc_sel = PC_ALU;
            default:  pc_sel = PC_PLUS4;
          endcase
        end
        ST_TRAP: begin
          illegal = 1'b1;
        end
        default: begin
          state_nxt = ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: per-cycle vector table, hand-written reset
// and trap sequences, and randomized instructions against a phase-sequence model.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
  import rv32_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we, retire, illegal;
  logic [1:0]  pc_sel, wb_sel;
  logic        alu_a_sel, alu_b_sel;
  logic [2:0]  imm_type, state_o;

  multicycle_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .reg_we       (reg_we),
    .retire       (retire),
    .illegal      (illegal),
    .pc_sel       (pc_sel),
    .wb_sel       (wb_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .imm_type     (imm_type),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic       retire;
    logic       illegal;
    logic [1:0] pc_sel;
    logic [1:0] wb_sel;
    logic       alu_a;
    logic       alu_b;
    logic [2:0] imm;
  } outs_t;

  typedef struct {
    int          rdy;
    int          tk;
    logic [31:0] ins;
    outs_t       exp;
    string       nm;
  } vec_t;

  typedef enum int {PH_FETCH, PH_DEC, PH_EXEC, PH_MEM, PH_WB} ph_e;

  localparam int SF = int'(ST_FETCH);
  localparam int SD = int'(ST_DECODE);
  localparam int SE = int'(ST_EXEC);
  localparam int SM = int'(ST_MEM);
  localparam int SW = int'(ST_WB);
  localparam int ST = int'(ST_TRAP);

  localparam logic [6:0] O_R = 7'h33, O_I = 7'h13, O_LD = 7'h03, O_ST = 7'h23, O_BR = 7'h63;
  localparam logic [6:0] O_LUI = 7'h37, O_AUI = 7'h17, O_JAL = 7'h6F, O_JALR = 7'h67;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_BNE  = 32'h00001463;
  localparam logic [31:0] I_ADD0 = 32'h00000033;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  int   nerr = 0;
  int   nchk = 0;
  vec_t tbl[$];

  function automatic outs_t mk(input int st, req, we, as, irwe, pcwe, regwe, ret, ill,
                               pcs, wbs, a, b, imm);
    outs_t e;
    e.state = st[2:0];     e.mem_req = req[0];   e.mem_we = we[0];
    e.mem_addr_sel = as[0]; e.ir_we = irwe[0];   e.pc_we = pcwe[0];
    e.reg_we = regwe[0];   e.retire = ret[0];    e.illegal = ill[0];
    e.pc_sel = pcs[1:0];   e.wb_sel = wbs[1:0];  e.alu_a = a[0];
    e.alu_b = b[0];        e.imm = imm[2:0];
    return e;
  endfunction

  function automatic outs_t actual();
    outs_t a;
    a.state = state_o;     a.mem_req = mem_req;  a.mem_we = mem_we;
    a.mem_addr_sel = mem_addr_sel; a.ir_we = ir_we; a.pc_we = pc_we;
    a.reg_we = reg_we;     a.retire = retire;    a.illegal = illegal;
    a.pc_sel = pc_sel;     a.wb_sel = wb_sel;    a.alu_a = alu_a_sel;
    a.alu_b = alu_b_sel;   a.imm = imm_type;
    return a;
  endfunction

  // Reference: expected outputs for one cycle of a given phase of an instruction.
  function automatic outs_t model(input ph_e ph, input logic [31:0] ins, input int rdy, input int tk);
    logic [6:0] op;
    int is_r, is_ld, is_st, is_br, is_lui, is_aui, is_jal, is_jalr, rdnz, imm, pcs, wbs;
    op      = ins[6:0];
    is_r    = int'(op == O_R);
    is_ld   = int'(op == O_LD);
    is_st   = int'(op == O_ST);
    is_br   = int'(op == O_BR);
    is_lui  = int'(op == O_LUI);
    is_aui  = int'(op == O_AUI);
    is_jal  = int'(op == O_JAL);
    is_jalr = int'(op == O_JALR);
    rdnz    = int'(ins[11:7] != 5'd0);
    if (op == O_I || is_ld != 0 || is_jalr != 0) imm = 0;
    else if (is_st != 0)                         imm = 1;
    else if (is_br != 0)                         imm = 2;
    else if (is_lui != 0 || is_aui != 0)         imm = 3;
    else if (is_jal != 0)                        imm = 4;
    else                                         imm = 7;
    pcs = (is_jal != 0) ? 1 : (is_jalr != 0) ? 2 : 0;
    wbs = (is_ld != 0) ? 1 : (is_jal != 0 || is_jalr != 0) ? 2 : (is_lui != 0) ? 3 : 0;
    case (ph)
      PH_FETCH: return mk(SF, 1, 0, 0, rdy, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      PH_DEC:   return mk(SD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, imm);
      PH_EXEC:  return mk(SE, 0, 0, 0, 0, is_br, 0, is_br, 0, (is_br != 0 && tk != 0) ? 1 : 0,
                          0, is_aui, int'(is_r == 0 && is_br == 0), imm);
      PH_MEM:   return mk(SM, 1, is_st, 1, 0, is_st & rdy, 0, is_st & rdy, 0, 0, 0, 0, 0, imm);
      default:  return mk(SW, 0, 0, 0, 0, 1, rdnz, 1, 0, pcs, wbs, 0, 0, imm);
    endcase
  endfunction

  task automatic check(input string nm, input outs_t exp);
    outs_t act;
    act = actual();
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %05h expected %05h", nm, act, exp);
    end
  endtask

  // Inputs are applied 1ns after a rising edge and outputs sampled at the falling edge.
  task automatic step(input int rdy, input int tk, input logic [31:0] ins, input outs_t exp,
                      input string nm);
    mem_ready    = rdy[0];
    branch_taken = tk[0];
    instr        = ins;
    @(negedge clk);
    check(nm, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int rdy, input int tk, input logic [31:0] ins, input outs_t exp,
                     input string nm);
    vec_t v;
    v.rdy = rdy; v.tk = tk; v.ins = ins; v.exp = exp; v.nm = nm;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(8, 0))
      0: r[6:0] = O_R;   1: r[6:0] = O_I;   2: r[6:0] = O_LD;
      3: r[6:0] = O_ST;  4: r[6:0] = O_BR;  5: r[6:0] = O_LUI;
      6: r[6:0] = O_AUI; 7: r[6:0] = O_JAL; default: r[6:0] = O_JALR;
    endcase
    if ($urandom_range(3, 0) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  // Runs one instruction from FETCH; memory phases repeat until mem_ready.
  task automatic run_instr(input logic [31:0] ins, input int rdy_pct);
    ph_e ph[$];
    ph.push_back(PH_FETCH);
    ph.push_back(PH_DEC);
    ph.push_back(PH_EXEC);
    if (ins[6:0] == O_LD || ins[6:0] == O_ST) ph.push_back(PH_MEM);
    if (ins[6:0] != O_BR && ins[6:0] != O_ST) ph.push_back(PH_WB);
    foreach (ph[i]) begin
      int waits;
      int rdy;
      int tk;
      logic [31:0] drv;
      waits = 0;
      do begin
        rdy = int'(($urandom_range(99, 0) < rdy_pct) || (waits >= 6));
        tk  = int'($urandom_range(1, 0));
        drv = (ph[i] == PH_FETCH) ? $urandom : ins;
        step(rdy, tk, drv, model(ph[i], ins, rdy, tk),
             $sformatf("rand_%08h_ph%0d_w%0d", ins, ph[i], waits));
        waits++;
      end while ((ph[i] == PH_FETCH || ph[i] == PH_MEM) && rdy == 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t z;
    z = mk(SF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ADDI x1,x0,5: 4 cycles
    add(1, 0, I_ADDI, mk(SF, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "addi_fetch");
    add(1, 0, I_ADDI, mk(SD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "addi_decode");
    add(1, 0, I_ADDI, mk(SE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "addi_exec");
    add(1, 0, I_ADDI, mk(SW, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0), "addi_wb");
    // BEQ taken: 3 cycles
    add(1, 1, I_BEQ, mk(SF, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "beq_fetch");
    add(1, 1, I_BEQ, mk(SD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), "beq_decode");
    add(1, 1, I_BEQ, mk(SE, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 2), "beq_exec");
    // BNE not taken
    add(1, 0, I_BNE, mk(SF, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "bne_fetch");
    add(1, 0, I_BNE, mk(SD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), "bne_decode");
    add(1, 0, I_BNE, mk(SE, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2), "bne_exec");
    // ADD x0,x0,x0: no register write
    add(1, 0, I_ADD0, mk(SF, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "add0_fetch");
    add(1, 0, I_ADD0, mk(SD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7), "add0_decode");
    add(1, 0, I_ADD0, mk(SE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7), "add0_exec");
    add(1, 0, I_ADD0, mk(SW, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 7), "add0_wb");
    // LW x2,0(x1) with three MEM wait cycles: 8 cycles
    add(1, 0, I_LW, mk(SF, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_fetch");
    add(1, 0, I_LW, mk(SD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_decode");
    add(1, 0, I_LW, mk(SE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "lw_exec");
    add(0, 0, I_LW, mk(SM, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_mem_wait1");
    add(0, 0, I_LW, mk(SM, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_mem_wait2");
    add(0, 0, I_LW, mk(SM, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_mem_wait3");
    add(1, 0, I_LW, mk(SM, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_mem_done");
    add(1, 0, I_LW, mk(SW, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0), "lw_wb");
    // SW retires from MEM
    add(1, 0, I_SW, mk(SF, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sw_fetch");
    add(1, 0, I_SW, mk(SD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "sw_decode");
    add(1, 0, I_SW, mk(SE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "sw_exec");
    add(1, 0, I_SW, mk(SM, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1), "sw_mem");
    add(0, 0, I_SW, mk(SF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "after_sw_fetch_wait");

    rst_n = 1'b0; mem_ready = 1'b1; branch_taken = 1'b0; instr = I_ADDI;
    #12;
    check("reset_state", z);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i].rdy, tbl[i].tk, tbl[i].ins, tbl[i].exp, tbl[i].nm);

    // Finish the pending fetch, then an illegal opcode traps until reset.
    step(1, 0, I_BAD, mk(SF, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "trap_fetch");
    step(1, 0, I_BAD, mk(SD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7), "trap_decode");
    for (int k = 0; k < 6; k++)
      step(int'($urandom_range(1, 0)), int'($urandom_range(1, 0)), $urandom,
           mk(ST, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), $sformatf("trap_hold%0d", k));
    rst_n = 1'b0;
    #2;
    check("trap_reset", z);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset dropped mid-cycle during a FETCH wait
    step(0, 0, I_ADDI, mk(SF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fwait1");
    step(0, 0, I_ADDI, mk(SF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fwait2");
    mem_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_fetch", z);
    @(posedge clk);
    #1;
    check("reset_held", z);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    step(0, 0, I_ADDI, mk(SF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_reset_req");
    run_instr(I_ADDI, 100);

    // Reset during a MEM wait abandons the load
    step(1, 0, I_LW, mk(SF, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mrst_fetch");
    step(1, 0, I_LW, mk(SD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mrst_decode");
    step(1, 0, I_LW, mk(SE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "mrst_exec");
    step(0, 0, I_LW, mk(SM, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mrst_mem_wait");
    mem_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("mem_abandon", z);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    rst_n = 1'b1;
    step(0, 0, I_LW, mk(SF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "after_mem_reset");

    // Randomized instruction stream with random memory stalls
    for (int n = 0; n < 150; n++) run_instr(rand_instr(), (n < 20) ? 100 : 60);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
